// File: rtl/ha_ctrl_pkg.sv
// Shared types and constant helpers for the serial half-adder controller.
package ha_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HA1  = 2'd1,
      HA2  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Width of the bit index counter for a given operand width.
   function automatic int idx_width(input int width);
      return $clog2(width + 1);
   endfunction

   // Clock edges from the accepting edge to out_valid rising.
   function automatic int done_latency(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/ha_cell.sv
// Purely combinational half adder shared by both passes of every bit.
module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one half-adder cell used twice per bit,
// with valid/ready handshakes on the operand and result sides.
module ha_serial_add_ctrl
   import ha_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  op_a,
   input  logic [WIDTH-1:0]                  op_b,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH-1:0]                  sum,
   output logic                              cout,
   output logic                              busy,
   output logic [idx_width(WIDTH)-1:0]       bit_idx
);

   localparam int              IDX_W    = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic             s1;
   logic             c1;

   logic             cell_a;
   logic             cell_b;
   logic             cell_s;
   logic             cell_c;
   logic             carry_next;
   logic [WIDTH-1:0] sum_shifted;

   // HA2 adds the partial sum to the running carry; HA1 adds the operand bits.
   assign cell_a     = (state == HA2) ? s1    : a_sh[0];
   assign cell_b     = (state == HA2) ? carry : b_sh[0];
   assign carry_next = c1 | cell_c;

   ha_cell u_cell (
      .a (cell_a),
      .b (cell_b),
      .s (cell_s),
      .c (cell_c)
   );

   // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_shifted = cell_s;
      end else begin : g_wn
         assign sum_shifted = {cell_s, sum[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         carry     <= 1'b0;
         s1        <= 1'b0;
         c1        <= 1'b0;
         bit_idx   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= op_a;
                  b_sh     <= op_b;
                  carry    <= 1'b0;
                  bit_idx  <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= HA1;
               end
            end
            HA1: begin
               s1    <= cell_s;
               c1    <= cell_c;
               state <= HA2;
            end
            HA2: begin
               sum   <= sum_shifted;
               carry <= carry_next;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               if (bit_idx == LAST_IDX) begin
                  cout      <= carry_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  bit_idx <= bit_idx + IDX_W'(1);
                  state   <= HA1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Bench for ha_serial_add_ctrl: directed vector table, random transactions
// against an arithmetic model, reset abort and a WIDTH=1 instance.
module tb_ha_serial_add_ctrl;
   import ha_ctrl_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, cout, busy;
   logic [W-1:0] op_a, op_b, sum;
   logic [3:0]   bit_idx;

   logic         in_valid1, in_ready1, out_valid1, out_ready1, cout1, busy1;
   logic [0:0]   op_a1, op_b1, sum1;
   logic [0:0]   bit_idx1;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ha_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy), .bit_idx(bit_idx)
   );

   ha_serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .op_a(op_a1), .op_b(op_b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1), .bit_idx(bit_idx1)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           hold;
      bit           noise;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the WIDTH=8 instance.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit noise, input logic [W-1:0] es, input logic ec,
                          input string name);
      int k;
      bit seq_ok;
      bit hold_ok;
      check({name, " in_ready before"}, 32'(in_ready), 32'd1);
      out_ready = (hold == 0);
      op_a      = a;
      op_b      = b;
      in_valid  = 1'b1;
      step();
      in_valid = noise;
      k        = 0;
      seq_ok   = 1'b1;
      while (!out_valid && k < 200) begin
         if (bit_idx !== 4'(k / 2) || busy !== 1'b1 || in_ready !== 1'b0) seq_ok = 1'b0;
         if (noise) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
         end
         step();
         k++;
      end
      in_valid = 1'b0;
      check({name, " latency"}, 32'(k), 32'(done_latency(W)));
      check({name, " busy/bit_idx sequence"}, 32'(seq_ok), 32'd1);
      check({name, " sum"}, 32'(sum), 32'(es));
      check({name, " cout"}, 32'(cout), 32'(ec));
      if (hold > 0) begin
         hold_ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            step();
            if (sum !== es || cout !== ec || out_valid !== 1'b1 || in_ready !== 1'b0)
               hold_ok = 1'b0;
         end
         check({name, " held result"}, 32'(hold_ok), 32'd1);
         out_ready = 1'b1;
      end
      step();
      check({name, " back to idle {out_valid,in_ready,busy}"},
            32'({out_valid, in_ready, busy}), 32'b010);
      out_ready = 1'b0;
   endtask

   task automatic run_w1(input logic a, input logic b);
      int k;
      logic [1:0] model;
      model      = 2'(a) + 2'(b);
      out_ready1 = 1'b1;
      op_a1      = a;
      op_b1      = b;
      in_valid1  = 1'b1;
      step();
      in_valid1 = 1'b0;
      k = 0;
      while (!out_valid1 && k < 50) begin
         step();
         k++;
      end
      check($sformatf("w1 %0d+%0d latency", a, b), 32'(k), 32'(done_latency(1)));
      check($sformatf("w1 %0d+%0d {cout,sum}", a, b), 32'({cout1, sum1}), 32'(model));
      step();
      check($sformatf("w1 %0d+%0d idle", a, b), 32'({out_valid1, in_ready1}), 32'b01);
   endtask

   vec_t vecs[4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [W:0]   model;

      vecs[0] = '{a: 8'h5A, b: 8'h33, hold: 0,  noise: 1'b0, exp_sum: 8'h8D, exp_cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, hold: 0,  noise: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
      vecs[2] = '{a: 8'hC8, b: 8'h64, hold: 10, noise: 1'b0, exp_sum: 8'h2C, exp_cout: 1'b1};
      vecs[3] = '{a: 8'h0F, b: 8'h01, hold: 0,  noise: 1'b1, exp_sum: 8'h10, exp_cout: 1'b0};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; op_a1 = '0; op_b1 = '0;
      step();
      step();
      check("reset {out_valid,in_ready,busy,cout}", 32'({out_valid, in_ready, busy, cout}), 32'b0100);
      check("reset sum", 32'(sum), 32'd0);
      check("reset bit_idx", 32'(bit_idx), 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].noise,
                 vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
         $display("vec%0d: 0x%02h + 0x%02h -> sum 0x%02h cout %0d", i, vecs[i].a, vecs[i].b, sum, cout);
      end

      for (int i = 0; i < 20; i++) begin
         ra    = W'($urandom);
         rb    = W'($urandom);
         model = (W+1)'(ra) + (W+1)'(rb);
         run_txn(ra, rb, int'($urandom_range(0, 3)), 1'b0, model[W-1:0], model[W],
                 $sformatf("rnd%0d", i));
         $display("rnd%0d: 0x%02h + 0x%02h -> expected 0x%03h", i, ra, rb, model);
      end

      // Reset in the middle of a computation aborts it cleanly.
      out_ready = 1'b1;
      op_a = 8'hAA; op_b = 8'h55; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      rst = 1'b1;
      #1;
      check("abort {out_valid,in_ready,busy,cout}", 32'({out_valid, in_ready, busy, cout}), 32'b0100);
      check("abort sum", 32'(sum), 32'd0);
      check("abort bit_idx", 32'(bit_idx), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("after abort {out_valid,in_ready}", 32'({out_valid, in_ready}), 32'b01);
      run_txn(8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0, "post-abort");
      $display("abort: 0xAA+0x55 discarded, 0x00+0x00 -> sum 0x%02h cout %0d", sum, cout);

      for (int i = 0; i < 4; i++) begin
         run_w1(1'(i >> 1), 1'(i));
         $display("w1: %0d + %0d -> sum %0d cout %0d", i >> 1, i & 1, sum1, cout1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ha_serial_add_ctrl.md
Name: ha_serial_add_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit unsigned addition by time-sharing a single combinational half-adder cell.
- Each operand bit takes two half-adder passes: (a_i + b_i), then (partial sum + carry-in).
- Operands enter and the result leaves through valid/ready handshakes.
- Sits between an operand producer and a result consumer. It replaces a parallel adder where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept an operand pair
- op_a  input  WIDTH  operand A, sampled on input handshake
- op_b  input  WIDTH  operand B, sampled on input handshake
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum (op_a + op_b) mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB
- busy  output  1  high in HA1/HA2/DONE
- bit_idx  output  $clog2(WIDTH+1)  index of the bit currently being processed

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - sum, cout, bit_idx, internal shift registers, carry, s1 and c1 all = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
- States: IDLE, HA1, HA2, DONE (2-bit encoding).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: capture op_a/op_b into shift regs; carry = 0; bit_idx = 0; go to HA1.
- HA1:
  - Half-adder inputs = a_sh[0], b_sh[0].
  - Register s1 = sum and c1 = carry from the cell; go to HA2.
- HA2:
  - Half-adder inputs = s1, carry.
  - Result bit = cell sum. It is shifted into sum from the MSB side (right shift), so sum is correctly aligned after WIDTH bits.
  - carry = c1 | cell carry.
  - Shift a_sh/b_sh right by 1.
  - If bit_idx == WIDTH-1: cout = new carry; go to DONE. Otherwise bit_idx++ and go to HA1.
- DONE:
  - out_valid = 1; sum and cout held stable.
  - On out_ready: go to IDLE at the next edge. out_valid drops in the same cycle that state leaves DONE.
- Latency:
  - out_valid rises exactly 2*WIDTH clock edges after the accepting edge (WIDTH=8: 16 cycles).
  - Minimum initiation interval = 2*WIDTH + 2 cycles (DONE handshake plus one IDLE cycle).
- in_ready is 0 in HA1/HA2/DONE. in_valid there is ignored, and op_a/op_b changes have no effect.
- out_valid with out_ready low: the result is held indefinitely with no change to sum/cout.
- out_ready while not in DONE has no effect.
- Reset mid-operation aborts the computation:
  - All state clears immediately (async).
  - No partial result is ever presented; the next transaction starts fresh.
- sum/cout are meaningful only while out_valid = 1. During HA1/HA2 they reflect partial shifting and must not be sampled.
- WIDTH = 1: single HA1→HA2 pair; out_valid rises 2 cycles after acceptance.
- Overflow wraps mod 2^WIDTH; the lost bit appears only on cout.

Decomposition:
- Package ha_ctrl_pkg:
  - state typedef (IDLE, HA1, HA2, DONE)
  - localparam IDX_W = $clog2(WIDTH+1) helper function
  - the DONE latency constant function (2*WIDTH) for bench checks
- One sub-module: ha_cell, a purely combinational half adder (s = a ^ b, c = a & b). It is instantiated once and muxed between the HA1/HA2 operand sources.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x33, out_ready=1 → out_valid after 16 cycles, sum=0x8D, cout=0, single-cycle out_valid.
- op_a=0xFF, op_b=0x01 → sum=0x00, cout=1; bit_idx steps 0..7 across HA2 states.
- op_a=0xC8, op_b=0x64, out_ready held 0 for 10 cycles after out_valid → sum=0x2C, cout=1 stable throughout; in_ready stays 0; IDLE entered one cycle after out_ready=1.
- Accept 0x0F+0x01, then toggle op_a/op_b and hold in_valid=1 during HA1/HA2 → no second acceptance; result sum=0x10, cout=0.
- Assert rst at cycle 7 of a 0xAA+0x55 transaction → outputs 0 immediately, in_ready=1 after release. A following 0x00+0x00 then gives sum=0x00, cout=0 after 16 cycles.
- WIDTH=1 build: 1+1 → sum=0, cout=1, out_valid 2 cycles after acceptance.
